// File: rtl/tag_rx_fifo.sv
// tag_rx_fifo: small first-in first-out receive buffer with valid/ready
// handshakes on both sides, a registered output word and a sticky overflow
// flag. Status outputs (ready, valid) come only from the registered count,
// so there is no combinational path from any input to any output.
module tag_rx_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_in_valid,
    input  logic [WIDTH-1:0]           i_in_data,
    output logic                       o_in_ready,
    output logic                       o_out_valid,
    output logic [WIDTH-1:0]           o_out_data,
    input  logic                       i_out_ready,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Storage and state
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_out_data;
    logic             r_overflow;

    // Handshake decode
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_pop;
    logic [AW-1:0]    w_wr_ptr_next;
    logic [AW-1:0]    w_rd_ptr_next;
    logic [CW-1:0]    w_count_next;
    logic [WIDTH-1:0] w_head_next;

    // Ready/valid depend on the registered count only.
    assign w_in_ready  = (r_count < CW'(DEPTH));
    assign w_out_valid = (r_count != '0);
    assign w_accept    = i_in_valid & w_in_ready;
    assign w_pop       = w_out_valid & i_out_ready;

    // Next pointer and count values; pointers wrap naturally at DEPTH
    // because DEPTH is a power of two.
    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        w_count_next  = r_count;
        if (w_accept) begin
            w_wr_ptr_next = r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
            w_rd_ptr_next = r_rd_ptr + AW'(1);
        end
        case ({w_accept, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Word that will sit at the head after this edge. The incoming word is
    // forwarded when it lands in the head slot, which happens exactly when
    // the buffer is (or becomes) empty at the moment of the write.
    always_comb begin
        w_head_next = r_mem[w_rd_ptr_next];
        if (w_accept && (r_wr_ptr == w_rd_ptr_next)) begin
            w_head_next = i_in_data;
        end
    end

    // Storage array: cleared on reset so the head register never reads X.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_accept) begin
            r_mem[r_wr_ptr] <= i_in_data;
        end
    end

    // Pointers, occupancy and registered head word.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_out_data <= '0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_next;
            r_rd_ptr   <= w_rd_ptr_next;
            r_count    <= w_count_next;
            r_out_data <= w_head_next;
        end
    end

    // Sticky overflow: a word offered while not ready is dropped and
    // remembered until reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_overflow <= 1'b0;
        end else if (i_in_valid && !w_in_ready) begin
            r_overflow <= 1'b1;
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = w_out_valid;
    assign o_out_data  = r_out_data;
    assign o_count     = r_count;
    assign o_overflow  = r_overflow;

endmodule
